// File: rtl/wb_arbiter_pkg.sv
// Shared CPU package for the writeback arbiter.
// Holds the register-file geometry constants and the load-buffer entry type.
package wb_arbiter_pkg;

   localparam int REG_W      = 16;
   localparam int REG_ADDR_W = 3;
   localparam int NUM_REGS   = 8;

   // One buffered load result: destination register plus data.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_W-1:0]      data;
   } ld_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter.
// master modport: the surrounding pipeline (drives ALU/load/issue inputs,
//                 observes the register-file write port and status).
// slave modport : the arbiter itself.
interface wb_arbiter_if;
   import wb_arbiter_pkg::*;

   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [REG_W-1:0]      alu_data;

   logic                  mem_valid;
   logic                  mem_ready;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [REG_W-1:0]      mem_data;

   logic                  issue_valid;
   logic [REG_ADDR_W-1:0] issue_rd;

   logic                  wen;
   logic [REG_ADDR_W-1:0] waddr;
   logic [REG_W-1:0]      wdata;
   logic [NUM_REGS-1:0]   busy;
   logic                  waw_err;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      output issue_valid, issue_rd,
      input  mem_ready, wen, waddr, wdata, busy, waw_err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      input  issue_valid, issue_rd,
      output mem_ready, wen, waddr, wdata, busy, waw_err
   );

endinterface

// File: rtl/wb_fifo.sv
// Load-result buffer for the writeback arbiter.
// Ports: clk, rst_n (async active-low), push/din (write), pop (read),
//        head (current oldest entry, valid when !empty), full, empty.
// A push while full is only honoured if a pop happens in the same cycle.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  ld_entry_t din,
   output ld_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   ld_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr_reg];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_ok && !pop_ok)
            count_reg <= count_reg + 1'b1;
         else if (pop_ok && !push_ok)
            count_reg <= count_reg - 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible through count_reg.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results onto a
// single registered register-file write port, tracks pending loads in a
// per-register scoreboard and flags ALU writes to registers still awaiting
// a load (sticky waw_err).
// Ports: clk, rst_n (async active-low), bus (wb_arbiter_if.slave).
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_arbiter_if.slave  bus
);

   logic      push;
   logic      pop;
   logic      full;
   logic      empty;
   ld_entry_t din;
   ld_entry_t head;

   logic                  wen_reg,     wen_next;
   logic [REG_ADDR_W-1:0] waddr_reg,   waddr_next;
   logic [REG_W-1:0]      wdata_reg,   wdata_next;
   logic [NUM_REGS-1:0]   busy_reg,    busy_next;
   logic                  waw_err_reg, waw_err_next;
   logic [NUM_REGS-1:0]   set_vec;
   logic [NUM_REGS-1:0]   clr_vec;

   assign bus.mem_ready = !full;
   assign push          = bus.mem_valid && !full;
   // The ALU has no backpressure, so loads only drain in ALU-idle cycles.
   assign pop           = !bus.alu_valid && !empty;
   assign din.rd        = bus.mem_rd;
   assign din.data      = bus.mem_data;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   // Register 0 is never tracked.
   assign set_vec[0] = 1'b0;
   assign clr_vec[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_score
         assign set_vec[gi] = bus.issue_valid && (bus.issue_rd == REG_ADDR_W'(gi));
         assign clr_vec[gi] = pop && (head.rd == REG_ADDR_W'(gi));
      end
   endgenerate

   always_comb begin
      wen_next     = 1'b0;
      waddr_next   = waddr_reg;
      wdata_next   = wdata_reg;
      waw_err_next = waw_err_reg;
      if (bus.alu_valid) begin
         wen_next   = (bus.alu_rd != '0);
         waddr_next = bus.alu_rd;
         wdata_next = bus.alu_data;
         if ((bus.alu_rd != '0) && busy_reg[bus.alu_rd])
            waw_err_next = 1'b1;
      end else if (!empty) begin
         wen_next   = (head.rd != '0);
         waddr_next = head.rd;
         wdata_next = head.data;
      end
      // Clear first, then set, so a coinciding issue keeps the bit set.
      busy_next = (busy_reg & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_reg     <= 1'b0;
         waddr_reg   <= '0;
         wdata_reg   <= '0;
         busy_reg    <= '0;
         waw_err_reg <= 1'b0;
      end else begin
         wen_reg     <= wen_next;
         waddr_reg   <= waddr_next;
         wdata_reg   <= wdata_next;
         busy_reg    <= busy_next;
         waw_err_reg <= waw_err_next;
      end
   end

   assign bus.wen     = wen_reg;
   assign bus.waddr   = waddr_reg;
   assign bus.wdata   = wdata_reg;
   assign bus.busy    = busy_reg;
   assign bus.waw_err = waw_err_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios, a queue-based reference
// model checked every clock, and literal expectations pinning the model.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int FIFO_DEPTH = 2;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   wb_arbiter_if bus ();

   wb_arbiter #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   ld_entry_t             mq[$];
   logic [NUM_REGS-1:0]   m_busy;
   logic                  m_err;
   logic [REG_ADDR_W-1:0] m_addr;
   logic [REG_W-1:0]      m_data;
   logic                  m_hold_ok;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_busy    = '0;
      m_err     = 1'b0;
      m_addr    = '0;
      m_data    = '0;
      m_hold_ok = 1'b1;
   endtask

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_data    = '0;
      bus.mem_valid   = 1'b0;
      bus.mem_rd      = '0;
      bus.mem_data    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
   endtask

   task automatic chk_reset();
      chk("rst_wen",   32'(bus.wen),       32'd0);
      chk("rst_waddr", 32'(bus.waddr),     32'd0);
      chk("rst_wdata", 32'(bus.wdata),     32'd0);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_err",   32'(bus.waw_err),   32'd0);
      chk("rst_ready", 32'(bus.mem_ready), 32'd1);
   endtask

   // One clock: predict from current inputs, clock, then compare.
   task automatic tick();
      logic      acc;
      logic      has_cand;
      logic      e_wen;
      ld_entry_t e;
      ld_entry_t n;
      chk("mem_ready", 32'(bus.mem_ready), 32'(mq.size() < FIFO_DEPTH));
      acc      = bus.mem_valid && (mq.size() < FIFO_DEPTH);
      has_cand = 1'b0;
      e_wen    = 1'b0;
      if (bus.alu_valid) begin
         has_cand = 1'b1;
         e_wen    = (bus.alu_rd != 0);
         if (e_wen && m_busy[bus.alu_rd]) m_err = 1'b1;
         if (e_wen) begin
            m_addr = bus.alu_rd;
            m_data = bus.alu_data;
         end
      end else if (mq.size() > 0) begin
         e        = mq.pop_front();
         has_cand = 1'b1;
         e_wen    = (e.rd != 0);
         m_busy[e.rd] = 1'b0;
         if (e_wen) begin
            m_addr = e.rd;
            m_data = e.data;
         end
      end
      if (has_cand) m_hold_ok = e_wen;
      if (acc) begin
         n.rd   = bus.mem_rd;
         n.data = bus.mem_data;
         mq.push_back(n);
      end
      if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
      @(posedge clk);
      #1;
      chk("wen", 32'(bus.wen), 32'(e_wen));
      if (m_hold_ok) begin
         chk("waddr", 32'(bus.waddr), 32'(m_addr));
         chk("wdata", 32'(bus.wdata), 32'(m_data));
      end
      chk("busy",    32'(bus.busy),    32'(m_busy));
      chk("waw_err", 32'(bus.waw_err), 32'(m_err));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle();
      m_reset();
      rst_n = 1'b0;
      #12;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Single ALU write: one-cycle latency, then idle
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 16'h1234;
      tick();
      chk("alu_wen",   32'(bus.wen),   32'd1);
      chk("alu_waddr", 32'(bus.waddr), 32'd3);
      chk("alu_wdata", 32'(bus.wdata), 32'h1234);
      idle();
      tick();
      chk("alu_wen_off", 32'(bus.wen), 32'd0);

      // Issue r5, load r5 held off by three ALU cycles
      bus.issue_valid = 1'b1; bus.issue_rd = 3'd5;
      tick();
      chk("issue5_busy", 32'(bus.busy), 32'h20);
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h1111;
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd5; bus.mem_data = 16'hBEEF;
      tick();
      bus.mem_valid = 1'b0;
      tick();
      tick();
      chk("ld5_busy_held", 32'(bus.busy), 32'h20);
      bus.alu_valid = 1'b0;
      tick();
      chk("ld5_wen",   32'(bus.wen),   32'd1);
      chk("ld5_waddr", 32'(bus.waddr), 32'd5);
      chk("ld5_wdata", 32'(bus.wdata), 32'hBEEF);
      chk("ld5_busy",  32'(bus.busy),  32'h00);

      // Three loads back-to-back under continuous ALU traffic
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h2222;
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd4; bus.mem_data = 16'hA004;
      tick();
      bus.mem_rd = 3'd6; bus.mem_data = 16'hA006;
      tick();
      bus.mem_rd = 3'd7; bus.mem_data = 16'hA007;
      chk("full_ready", 32'(bus.mem_ready), 32'd0);
      tick();
      bus.alu_valid = 1'b0;
      tick();
      chk("drain0_addr", 32'(bus.waddr), 32'd4);
      chk("drain0_data", 32'(bus.wdata), 32'hA004);
      tick();
      chk("drain1_addr", 32'(bus.waddr), 32'd6);
      bus.mem_valid = 1'b0;
      tick();
      chk("drain2_addr", 32'(bus.waddr), 32'd7);
      chk("drain2_data", 32'(bus.wdata), 32'hA007);
      tick();
      chk("hold_wen",   32'(bus.wen),   32'd0);
      chk("hold_waddr", 32'(bus.waddr), 32'd7);

      // WAW hazard: ALU writes r2 while a load to r2 is pending
      bus.issue_valid = 1'b1; bus.issue_rd = 3'd2;
      tick();
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd2; bus.alu_data = 16'h5555;
      tick();
      chk("waw_set",   32'(bus.waw_err), 32'd1);
      chk("waw_wen",   32'(bus.wen),     32'd1);
      chk("waw_waddr", 32'(bus.waddr),   32'd2);
      idle();
      tick();
      tick();
      chk("waw_sticky", 32'(bus.waw_err), 32'd1);

      // Destination 0 from ALU and load; issue to r0 ignored
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd0; bus.alu_data = 16'h0BAD;
      bus.issue_valid = 1'b1; bus.issue_rd = 3'd0;
      tick();
      chk("r0_alu_wen", 32'(bus.wen), 32'd0);
      idle();
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd0; bus.mem_data = 16'h0C0C;
      tick();
      bus.mem_valid = 1'b0;
      tick();
      chk("r0_ld_wen", 32'(bus.wen), 32'd0);
      tick();
      chk("r0_busy", 32'(bus.busy), 32'h04);

      // Set and clear of busy[3] in the same edge: set wins
      bus.issue_valid = 1'b1; bus.issue_rd = 3'd3;
      tick();
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h3000;
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd3; bus.mem_data = 16'h3333;
      tick();
      idle();
      bus.issue_valid = 1'b1; bus.issue_rd = 3'd3;
      tick();
      chk("setwin_waddr", 32'(bus.waddr), 32'd3);
      chk("setwin_busy",  32'(bus.busy),  32'h0C);
      idle();
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd3; bus.mem_data = 16'h3334;
      tick();
      bus.mem_valid = 1'b0;
      tick();
      chk("clr3_busy", 32'(bus.busy), 32'h04);

      // Asynchronous reset with two buffered loads and busy=0x24
      bus.issue_valid = 1'b1; bus.issue_rd = 3'd5;
      tick();
      chk("pre_rst_busy", 32'(bus.busy), 32'h24);
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h4444;
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd2; bus.mem_data = 16'h2222;
      tick();
      bus.mem_rd = 3'd5; bus.mem_data = 16'h5555;
      tick();
      chk("pre_rst_ready", 32'(bus.mem_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      idle();
      #1;
      m_reset();
      chk_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      chk("post_rst_wen", 32'(bus.wen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
